// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Programmable controller for the register-file/ALU datapath. It holds a
//   16 x 29-bit writable control store. After Start it steps through
//   microwords, drives the datapath control lines from the current word, and
//   branches on the Datapath result bus.
//
// Ports
//   CLK, RST           clock (rising edge), synchronous active-high reset
//   Start              begin execution at START_ADDR (sampled in IDLE only)
//   Load_En/Addr/Data  control store write port (honoured in IDLE only)
//   Datapath           result bus from the datapath, used as branch condition
//   IE, OE             datapath input/output enables
//   WE, WA             register file write enable/address
//   REA, RAA           read port A enable/address
//   REB, RAB           read port B enable/address
//   S_ALU1, Cin        ALU function select and carry-in
//   Done               HALT word executing (one cycle per completed run)
//   Busy               high while in RUN
//   Err                sticky watchdog timeout flag
//   PC                 current microword address (debug)
//
// Microword: [28:26] COND, [25:22] NEXT, [21] WE, [20:17] WA, [16] REA,
//            [15:12] RAA, [11] REB, [10:7] RAB, [6:3] S_ALU1, [2] Cin,
//            [1] IE, [0] OE

module microcode_sequencer #(
    parameter int unsigned DW         = 16,
    parameter logic [3:0]  START_ADDR = 4'd0,
    parameter int unsigned MAX_STEPS  = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          Start,
    input  logic          Load_En,
    input  logic [3:0]    Load_Addr,
    input  logic [28:0]   Load_Data,
    input  logic [DW-1:0] Datapath,
    output logic          IE,
    output logic          OE,
    output logic          WE,
    output logic [3:0]    WA,
    output logic          REA,
    output logic [3:0]    RAA,
    output logic          REB,
    output logic [3:0]    RAB,
    output logic [3:0]    S_ALU1,
    output logic          Cin,
    output logic          Done,
    output logic          Busy,
    output logic          Err,
    output logic [3:0]    PC
);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    localparam logic [2:0] COND_JMP   = 3'b001;
    localparam logic [2:0] COND_BRZ   = 3'b010;
    localparam logic [2:0] COND_BRNZ  = 3'b011;
    localparam logic [2:0] COND_BRONE = 3'b100;
    localparam logic [2:0] COND_HALT  = 3'b101;

    // Watchdog fires on the RUN cycle whose step count equals this value.
    localparam logic [7:0] LAST_STEP = 8'(MAX_STEPS - 1);

    logic [28:0] r_store [16];
    state_t      r_state;
    logic [3:0]  r_pc;
    logic [7:0]  r_steps;
    logic        r_err;

    logic [28:0] w_word;
    logic        w_run;
    logic [2:0]  w_cond;
    logic [3:0]  w_next;
    logic        w_is_halt;
    logic        w_take;
    logic [3:0]  w_pc_next;

    assign w_word    = r_store[r_pc];
    assign w_run     = (r_state == StRun);
    assign w_cond    = w_word[28:26];
    assign w_next    = w_word[25:22];
    assign w_is_halt = (w_cond == COND_HALT);

    // Branch decision; unused encodings 110/111 fall through to sequential.
    always_comb begin
        w_take = 1'b0;
        case (w_cond)
            COND_JMP:   w_take = 1'b1;
            COND_BRZ:   w_take = (Datapath == '0);
            COND_BRNZ:  w_take = (Datapath != '0);
            COND_BRONE: w_take = (Datapath == DW'(1));
            default:    w_take = 1'b0;
        endcase
        w_pc_next = w_take ? w_next : (r_pc + 4'd1);
    end

    // Control store: cleared on reset, writable only while idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                r_store[i] <= '0;
            end
        end else if (!w_run && Load_En) begin
            r_store[Load_Addr] <= Load_Data;
        end
    end

    // Sequencer FSM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
            r_pc    <= 4'd0;
            r_steps <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (Start) begin
                        r_state <= StRun;
                        r_pc    <= START_ADDR;
                        r_steps <= 8'd0;
                        r_err   <= 1'b0;
                    end
                end
                StRun: begin
                    r_steps <= r_steps + 8'd1;
                    // PC is left on the final word so it stays visible in IDLE.
                    if (w_is_halt) begin
                        r_state <= StIdle;
                    end else if (r_steps == LAST_STEP) begin
                        r_state <= StIdle;
                        r_err   <= 1'b1;
                    end else begin
                        r_pc <= w_pc_next;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Outputs follow the current word combinationally and are forced low in IDLE.
    always_comb begin
        WE     = 1'b0;
        WA     = 4'd0;
        REA    = 1'b0;
        RAA    = 4'd0;
        REB    = 1'b0;
        RAB    = 4'd0;
        S_ALU1 = 4'd0;
        Cin    = 1'b0;
        IE     = 1'b0;
        OE     = 1'b0;
        Done   = 1'b0;
        if (w_run) begin
            WE     = w_word[21];
            WA     = w_word[20:17];
            REA    = w_word[16];
            RAA    = w_word[15:12];
            REB    = w_word[11];
            RAB    = w_word[10:7];
            S_ALU1 = w_word[6:3];
            Cin    = w_word[2];
            IE     = w_word[1];
            OE     = w_word[0];
            Done   = w_is_halt;
        end
    end

    assign Busy = w_run;
    assign Err  = r_err;
    assign PC   = r_pc;

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Start = 1'b0;
    logic        Load_En = 1'b0;
    logic [3:0]  Load_Addr = 4'd0;
    logic [28:0] Load_Data = '0;
    logic [15:0] Datapath = '0;
    logic        IE, OE, WE, REA, REB, Cin, Done, Busy, Err;
    logic [3:0]  WA, RAA, RAB, S_ALU1, PC;

    microcode_sequencer #(
        .DW        (16),
        .START_ADDR(4'd0),
        .MAX_STEPS (20)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Start    (Start),
        .Load_En  (Load_En),
        .Load_Addr(Load_Addr),
        .Load_Data(Load_Data),
        .Datapath (Datapath),
        .IE       (IE),
        .OE       (OE),
        .WE       (WE),
        .WA       (WA),
        .REA      (REA),
        .RAA      (RAA),
        .REB      (REB),
        .RAB      (RAB),
        .S_ALU1   (S_ALU1),
        .Cin      (Cin),
        .Done     (Done),
        .Busy     (Busy),
        .Err      (Err),
        .PC       (PC)
    );

    always #5 CLK = ~CLK;

    localparam logic [2:0] SEQ = 3'b000, JMP = 3'b001, BRZ = 3'b010;
    localparam logic [2:0] BRONE = 3'b100, HALT = 3'b101;

    logic [21:0] w_ctrl;
    assign w_ctrl = {WE, WA, REA, RAA, REB, RAB, S_ALU1, Cin, IE, OE};

    typedef struct {
        logic [15:0] dp;
        logic        st;
        logic        ld;
        logic        rst;
        logic        chk_pc;
        logic [3:0]  pc;
        logic        busy;
        logic        done;
        logic        err;
        logic [21:0] ctrl;
    } exp_t;

    exp_t        sb[$];
    logic [28:0] m_store [16];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] ctl(input logic we, input logic [3:0] wa, input logic rea,
                                        input logic [3:0] raa, input logic reb,
                                        input logic [3:0] rab, input logic [3:0] alu,
                                        input logic cin, input logic ie, input logic oe);
        return {we, wa, rea, raa, reb, rab, alu, cin, ie, oe};
    endfunction

    function automatic logic [28:0] mw(input logic [2:0] c, input logic [3:0] n,
                                       input logic [21:0] f);
        return {c, n, f};
    endfunction

    // Expected outputs for one cycle; control fields come from the shadow store.
    task automatic push(input logic [3:0] pc, input logic busy, input logic done,
                        input logic err, input logic [15:0] dp);
        exp_t e;
        e.dp     = dp;
        e.st     = 1'b0;
        e.ld     = 1'b0;
        e.rst    = 1'b0;
        e.chk_pc = busy;
        e.pc     = pc;
        e.busy   = busy;
        e.done   = done;
        e.err    = err;
        e.ctrl   = busy ? m_store[pc][21:0] : 22'd0;
        sb.push_back(e);
    endtask

    // Drive each queued cycle from a falling edge, compare 1 time unit later.
    task automatic drain(input string name);
        int   cyc = 0;
        exp_t e;
        while (sb.size() > 0) begin
            e         = sb.pop_front();
            Datapath  = e.dp;
            Start     = e.st;
            Load_En   = e.ld;
            Load_Addr = 4'd4;
            Load_Data = '0;
            RST       = e.rst;
            #1;
            check_eq($sformatf("%s[%0d] busy", name, cyc), 32'(Busy), 32'(e.busy));
            check_eq($sformatf("%s[%0d] done", name, cyc), 32'(Done), 32'(e.done));
            check_eq($sformatf("%s[%0d] err", name, cyc), 32'(Err), 32'(e.err));
            check_eq($sformatf("%s[%0d] ctrl", name, cyc), 32'(w_ctrl), 32'(e.ctrl));
            if (e.chk_pc) begin
                check_eq($sformatf("%s[%0d] pc", name, cyc), 32'(PC), 32'(e.pc));
            end
            @(negedge CLK);
            cyc++;
        end
        Start   = 1'b0;
        Load_En = 1'b0;
        RST     = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [28:0] d);
        Load_En   = 1'b1;
        Load_Addr = a;
        Load_Data = d;
        @(negedge CLK);
        Load_En   = 1'b0;
        m_store[a] = d;
    endtask

    task automatic start();
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic zero_run(input string name);
        for (int i = 0; i < 20; i++) begin
            push(4'(i % 16), 1'b1, 1'b0, 1'b0, 16'(i * 7));
        end
        push(4'd0, 1'b0, 1'b0, 1'b1, 16'd0);
        push(4'd0, 1'b0, 1'b0, 1'b1, 16'd0);
        drain(name);
    endtask

    initial begin
        @(negedge CLK);
        // Reset with random write/start attempts that must be ignored.
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            Start     = 1'($urandom_range(0, 1));
            Load_En   = 1'b1;
            Load_Addr = 4'($urandom_range(0, 15));
            Load_Data = 29'h1555_5555;
            @(negedge CLK);
        end
        RST = 1'b0;
        Start = 1'b0;
        Load_En = 1'b0;
        for (int i = 0; i < 16; i++) m_store[i] = '0;
        #1;
        check_eq("rst busy", 32'(Busy), 32'd0);
        check_eq("rst done", 32'(Done), 32'd0);
        check_eq("rst err", 32'(Err), 32'd0);
        check_eq("rst pc", 32'(PC), 32'd0);
        check_eq("rst ctrl", 32'(w_ctrl), 32'd0);
        @(negedge CLK);

        // Cleared store: 20-step watchdog with PC wrap, Err set, no Done.
        start();
        zero_run("wdog");

        // Single HALT; Start clears Err in its first RUN cycle.
        load(4'd0, mw(HALT, 4'd0, ctl(0, 0, 1, 3, 1, 0, 4'b0101, 0, 0, 1)));
        start();
        #1;
        check_eq("halt oe", 32'(OE), 32'd1);
        check_eq("halt raa", 32'(RAA), 32'd3);
        check_eq("halt alu", 32'(S_ALU1), 32'h5);
        push(4'd0, 1'b1, 1'b1, 1'b0, 16'd0);
        push(4'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        drain("halt");

        // BRZ taken and not taken.
        load(4'd0, mw(BRZ, 4'd5, 22'd0));
        load(4'd1, mw(HALT, 4'd0, ctl(1, 2, 0, 0, 0, 0, 0, 0, 0, 0)));
        load(4'd5, mw(HALT, 4'd0, ctl(1, 7, 0, 0, 0, 0, 0, 1, 1, 0)));
        start();
        push(4'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        push(4'd5, 1'b1, 1'b1, 1'b0, 16'h0000);
        push(4'd5, 1'b0, 1'b0, 1'b0, 16'h0000);
        drain("brz_t");
        start();
        push(4'd0, 1'b1, 1'b0, 1'b0, 16'h0003);
        push(4'd1, 1'b1, 1'b1, 1'b0, 16'h0003);
        push(4'd1, 1'b0, 1'b0, 1'b0, 16'h0003);
        drain("brz_n");

        // Loop with BRONE/JMP.
        load(4'd0, mw(SEQ, 4'd9, ctl(0, 0, 1, 1, 0, 0, 0, 0, 1, 0)));
        load(4'd1, mw(SEQ, 4'd0, ctl(0, 0, 0, 0, 1, 6, 4'b0011, 1, 0, 0)));
        load(4'd2, mw(BRONE, 4'd4, ctl(0, 0, 0, 0, 0, 0, 4'b1001, 0, 0, 0)));
        load(4'd3, mw(JMP, 4'd2, ctl(1, 9, 0, 0, 0, 0, 0, 0, 0, 0)));
        load(4'd4, mw(HALT, 4'd0, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
        for (int pass = 0; pass < 2; pass++) begin
            start();
            push(4'd0, 1'b1, 1'b0, 1'b0, 16'd5);
            push(4'd1, 1'b1, 1'b0, 1'b0, 16'd5);
            for (int k = 0; k < 3; k++) begin
                push(4'd2, 1'b1, 1'b0, 1'b0, 16'd5);
                push(4'd3, 1'b1, 1'b0, 1'b0, 16'd1);
            end
            push(4'd2, 1'b1, 1'b0, 1'b0, 16'd1);
            push(4'd4, 1'b1, 1'b1, 1'b0, 16'd5);
            push(4'd4, 1'b0, 1'b0, 1'b0, 16'd5);
            if (pass == 1) begin
                // Writes (zeroing the HALT at 4) and Start during RUN are ignored.
                sb[0].ld = 1'b1;
                sb[3].st = 1'b1;
                sb[8].ld = 1'b1;
            end
            drain(pass == 0 ? "loop" : "intf");
        end

        // Reset mid-run aborts to IDLE and clears the store.
        start();
        push(4'd0, 1'b1, 1'b0, 1'b0, 16'd5);
        push(4'd1, 1'b1, 1'b0, 1'b0, 16'd5);
        sb[1].rst = 1'b1;
        push(4'd0, 1'b0, 1'b0, 1'b0, 16'd5);
        sb[2].chk_pc = 1'b1;
        drain("mid_rst");
        for (int i = 0; i < 16; i++) m_store[i] = '0;
        start();
        zero_run("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
